// File: rtl/patgen_tx_if.sv
// Word handshake between a parallel-word source and the serial pattern transmitter.
interface patgen_tx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_i;
  logic             data_valid_i;
  logic             data_ready_o;

  modport master (output data_i, output data_valid_i, input data_ready_o);
  modport slave  (input data_i, input data_valid_i, output data_ready_o);
endinterface

// File: rtl/patgen_tx.sv
// Serialises handshaked words MSB-first onto a din/valid bit stream and keeps a
// golden model (pulse plus saturating count) of overlapping PATTERN occurrences.
module patgen_tx #(
  parameter int                 WIDTH   = 8,
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1101,
  parameter int                 GAP_CYC = 0,
  parameter int                 CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  patgen_tx_if.slave       bus,
  input  logic             en_i,
  output logic             dout_o,
  output logic             valid_o,
  output logic             busy_o,
  input  logic             cnt_clr_i,
  output logic             exp_det_o,
  output logic [CNT_W-1:0] exp_cnt_o
);

  localparam int                BCNT_W    = $clog2(WIDTH);
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(WIDTH - 1);
  localparam int                GCNT_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GCNT_W-1:0] GCNT_LAST = GCNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic [WIDTH-1:0]   sreg_r;
  logic [BCNT_W-1:0]  bcnt_r;
  logic [GCNT_W-1:0]  gcnt_r;
  logic [PAT_LEN-2:0] hist_r;
  logic [CNT_W-1:0]   cnt_r;

  logic               ready_s;
  logic               valid_s;
  logic               shift_s;
  logic               last_s;
  logic               load_s;
  logic               det_s;
  logic [PAT_LEN-1:0] win_s;

  // Window of the last PAT_LEN emitted bits, the one on dout_o being newest.
  assign win_s = {hist_r, sreg_r[WIDTH-1]};

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE:  state_s = load_s ? ST_SHIFT : ST_IDLE;
      ST_SHIFT: begin
        if (last_s) begin
          if (GAP_CYC == 0) begin
            state_s = load_s ? ST_SHIFT : ST_IDLE;
          end else begin
            state_s = ST_GAP;
          end
        end else begin
          state_s = ST_SHIFT;
        end
      end
      ST_GAP:   state_s = (gcnt_r == GCNT_LAST) ? ST_IDLE : ST_GAP;
      default:  state_s = ST_IDLE;
    endcase
  end

  // Output and strobe decode; ready is also offered on the final bit when back-to-back.
  always_comb begin
    ready_s = 1'b0;
    valid_s = 1'b0;
    shift_s = 1'b0;
    last_s  = 1'b0;
    case (state_r)
      ST_IDLE:  ready_s = 1'b1;
      ST_SHIFT: begin
        valid_s = en_i;
        shift_s = en_i;
        last_s  = en_i && (bcnt_r == BCNT_LAST);
        ready_s = (GAP_CYC == 0) && last_s;
      end
      ST_GAP:   ready_s = 1'b0;
      default:  ready_s = 1'b0;
    endcase
    load_s = ready_s && bus.data_valid_i;
    det_s  = valid_s && (win_s == PATTERN);
  end

  // Shift datapath: a load may coincide with consuming the last bit of the previous word.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sreg_r <= '0;
      bcnt_r <= '0;
      gcnt_r <= '0;
      hist_r <= '0;
    end else begin
      if (load_s) begin
        sreg_r <= bus.data_i;
        bcnt_r <= '0;
      end else if (shift_s) begin
        sreg_r <= {sreg_r[WIDTH-2:0], 1'b0};
        bcnt_r <= bcnt_r + BCNT_W'(1);
      end else begin
        sreg_r <= sreg_r;
        bcnt_r <= bcnt_r;
      end
      if (shift_s) begin
        hist_r <= win_s[PAT_LEN-2:0];
      end else begin
        hist_r <= hist_r;
      end
      if (last_s) begin
        gcnt_r <= '0;
      end else if (state_r == ST_GAP) begin
        gcnt_r <= gcnt_r + GCNT_W'(1);
      end else begin
        gcnt_r <= gcnt_r;
      end
    end
  end

  // Golden detect counter; clear wins over a simultaneous detect.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_r <= '0;
    end else if (cnt_clr_i) begin
      cnt_r <= '0;
    end else if (det_s && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign bus.data_ready_o = ready_s;
  assign valid_o          = valid_s;
  assign dout_o           = sreg_r[WIDTH-1];
  assign busy_o           = (state_r != ST_IDLE);
  assign exp_det_o        = det_s;
  assign exp_cnt_o        = cnt_r;

endmodule

// File: tb/tb_patgen_tx.sv
// Scoreboard bench for patgen_tx: one back-to-back instance and one with a 3-cycle
// gap and a 2-bit saturating counter, sharing clock, reset, enable and clear.
module tb_patgen_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        cnt_clr;
  logic        dout0, valid0, busy0, det0;
  logic        dout1, valid1, busy1, det1;
  logic [15:0] cnt0;
  logic [1:0]  cnt1;

  int total = 0;
  int bad   = 0;

  logic [1:0] q0[$];
  logic [1:0] q1[$];
  int run_len[2]   = '{0, 0};
  int last_run[2]  = '{0, 0};
  int idle_len[2]  = '{0, 0};
  int last_idle[2] = '{0, 0};

  patgen_tx_if #(.WIDTH(8)) if0 ();
  patgen_tx_if #(.WIDTH(8)) if1 ();

  patgen_tx u_dut0 (
    .clk_i(clk), .rst_i(rst), .bus(if0.slave), .en_i(en),
    .dout_o(dout0), .valid_o(valid0), .busy_o(busy0),
    .cnt_clr_i(cnt_clr), .exp_det_o(det0), .exp_cnt_o(cnt0)
  );

  patgen_tx #(.GAP_CYC(3), .CNT_W(2)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .bus(if1.slave), .en_i(en),
    .dout_o(dout1), .valid_o(valid1), .busy_o(busy1),
    .cnt_clr_i(cnt_clr), .exp_det_o(det1), .exp_cnt_o(cnt1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic mon(input int sel, input logic v, input logic d, input logic x);
    logic [1:0] e;
    int         qs;
    if (v) begin
      if (idle_len[sel] > 0) last_idle[sel] = idle_len[sel];
      idle_len[sel] = 0;
      run_len[sel]++;
      qs = (sel == 0) ? q0.size() : q1.size();
      if (qs == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_bit dut%0d actual=valid required=no_bit at %0t", sel, $time);
      end else begin
        if (sel == 0) e = q0.pop_front();
        else          e = q1.pop_front();
        check($sformatf("dout%0d", sel), {31'd0, d}, {31'd0, e[1]});
        check($sformatf("det%0d", sel), {31'd0, x}, {31'd0, e[0]});
      end
    end else begin
      if (run_len[sel] > 0) last_run[sel] = run_len[sel];
      run_len[sel] = 0;
      idle_len[sel]++;
      check($sformatf("idle_det%0d", sel), {31'd0, x}, 32'd0);
    end
  endtask

  // Monitor: every valid bit is matched against the queued expectation.
  always @(negedge clk) begin
    if (rst) begin
      mon(0, valid0, dout0, det0);
      mon(1, valid1, dout1, det1);
    end
  end

  // Offer one word, wait for the handshake, queue its expected bits and detects.
  task automatic send(input int sel, input logic [7:0] w, input logic [7:0] mask);
    int   n;
    logic rdy;
    if (sel == 0) begin
      if0.data_i = w;
      if0.data_valid_i = 1'b1;
    end else begin
      if1.data_i = w;
      if1.data_valid_i = 1'b1;
    end
    n = 0;
    #1;
    rdy = (sel == 0) ? if0.data_ready_o : if1.data_ready_o;
    while (!rdy && n < 100) begin
      @(posedge clk); #2;
      n++;
      rdy = (sel == 0) ? if0.data_ready_o : if1.data_ready_o;
    end
    check($sformatf("accept%0d", sel), {31'd0, rdy}, 32'd1);
    if (rdy) begin
      for (int i = 7; i >= 0; i--) begin
        if (sel == 0) q0.push_back({w[i], mask[i]});
        else          q1.push_back({w[i], mask[i]});
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic drop(input int sel);
    if (sel == 0) if0.data_valid_i = 1'b0;
    else          if1.data_valid_i = 1'b0;
  endtask

  task automatic wait_done(input int sel);
    int   n;
    logic b;
    n = 0;
    b = (sel == 0) ? busy0 : busy1;
    while (b && n < 200) begin
      @(posedge clk); #1;
      n++;
      b = (sel == 0) ? busy0 : busy1;
    end
    check($sformatf("done%0d", sel), {31'd0, b}, 32'd0);
    @(posedge clk); #1;
    check($sformatf("q_empty%0d", sel), (sel == 0) ? q0.size() : q1.size(), 32'd0);
  endtask

  task automatic clr();
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    check("clr_cnt0", {16'd0, cnt0}, 32'd0);
    check("clr_cnt1", {30'd0, cnt1}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    en = 1'b1;
    cnt_clr = 1'b0;
    if0.data_i = 8'h00; if0.data_valid_i = 1'b0;
    if1.data_i = 8'h00; if1.data_valid_i = 1'b0;
    #1;
    check("rst_valid", {31'd0, valid0}, 32'd0);
    check("rst_dout",  {31'd0, dout0},  32'd0);
    check("rst_det",   {31'd0, det0},   32'd0);
    check("rst_busy",  {31'd0, busy0},  32'd0);
    check("rst_cnt",   {16'd0, cnt0},   32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rst_ready0", {31'd0, if0.data_ready_o}, 32'd1);
    check("rst_ready1", {31'd0, if1.data_ready_o}, 32'd1);
    @(posedge clk); #1;

    // Single word 1101_0000: detect on the 4th bit.
    clr();
    send(0, 8'hD0, 8'b0001_0000);
    drop(0);
    wait_done(0);
    check("single_cnt", {16'd0, cnt0}, 32'd1);

    // Overlap 1101_1011: detects on bits 4 and 7.
    clr();
    send(0, 8'hDB, 8'b0001_0010);
    drop(0);
    wait_done(0);
    check("overlap_cnt", {16'd0, cnt0}, 32'd2);

    // Cross-word back-to-back 0000_0001 then 1010_0000: detect on 3rd bit of word 2.
    clr();
    send(0, 8'h01, 8'b0000_0000);
    send(0, 8'hA0, 8'b0010_0000);
    drop(0);
    wait_done(0);
    check("cross_cnt", {16'd0, cnt0}, 32'd1);
    check("cross_run", last_run[0], 32'd16);

    // Same words through the gapped instance: 3 gap cycles plus 1 handshake cycle.
    clr();
    send(1, 8'h01, 8'b0000_0000);
    send(1, 8'hA0, 8'b0010_0000);
    drop(1);
    wait_done(1);
    check("gap_cnt", {30'd0, cnt1}, 32'd1);
    check("gap_idle", last_idle[1], 32'd4);

    // Two more overlapping words push the 2-bit counter past its maximum.
    send(1, 8'hDB, 8'b0001_0010);
    send(1, 8'hDB, 8'b0001_0010);
    drop(1);
    wait_done(1);
    check("sat_cnt", {30'd0, cnt1}, 32'd3);

    // Clear asserted on the detect cycle wins.
    clr();
    send(0, 8'hD0, 8'b0001_0000);
    drop(0);
    repeat (3) begin @(posedge clk); #1; end
    cnt_clr = 1'b1;
    #1;
    check("prio_det", {31'd0, det0}, 32'd1);
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    check("prio_cnt", {16'd0, cnt0}, 32'd0);
    wait_done(0);
    check("prio_cnt_end", {16'd0, cnt0}, 32'd0);

    // Stall for 5 cycles after the 2nd bit: bit 3 (a 0) is held, not emitted.
    clr();
    send(0, 8'hD0, 8'b0001_0000);
    drop(0);
    repeat (2) begin @(posedge clk); #1; end
    en = 1'b0;
    repeat (5) begin
      #1;
      check("stall_valid", {31'd0, valid0}, 32'd0);
      check("stall_dout",  {31'd0, dout0},  32'd0);
      @(posedge clk); #1;
    end
    en = 1'b1;
    wait_done(0);
    check("stall_cnt", {16'd0, cnt0}, 32'd1);

    // Reset during the 3rd bit of 1101_1011.
    send(0, 8'hDB, 8'b0001_0010);
    drop(0);
    repeat (2) begin @(posedge clk); #1; end
    check("pre_rst_valid", {31'd0, valid0}, 32'd1);
    rst = 1'b0;
    q0.delete();
    #1;
    check("mid_rst_valid", {31'd0, valid0}, 32'd0);
    check("mid_rst_dout",  {31'd0, dout0},  32'd0);
    check("mid_rst_det",   {31'd0, det0},   32'd0);
    check("mid_rst_busy",  {31'd0, busy0},  32'd0);
    check("mid_rst_cnt",   {16'd0, cnt0},   32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("post_rst_ready", {31'd0, if0.data_ready_o}, 32'd1);
    check("post_rst_cnt",   {16'd0, cnt0}, 32'd0);
    repeat (4) begin
      @(posedge clk); #1;
      check("post_rst_valid", {31'd0, valid0}, 32'd0);
    end

    // Clean operation after reset.
    send(0, 8'hD0, 8'b0001_0000);
    drop(0);
    wait_done(0);
    check("after_rst_cnt", {16'd0, cnt0}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
